// File: rtl/adder_scheduler32_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_scheduler32_if                                                     |
// | Request/result handshake bundle for the shared-adder scheduler.          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface adder_scheduler32_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*WIDTH-1:0] add1_i;
    logic [NREQ*WIDTH-1:0] add2_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [WIDTH:0]        result_o;
    logic [1:0]            res_id_o;
    logic [15:0]           ops_cnt_o;

    modport master (
        output req_valid_i, add1_i, add2_i, res_ready_i,
        input  req_ready_o, res_valid_o, result_o, res_id_o, ops_cnt_o
    );

    modport slave (
        input  req_valid_i, add1_i, add2_i, res_ready_i,
        output req_ready_o, res_valid_o, result_o, res_id_o, ops_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/adder_scheduler32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_scheduler32                                                        |
// | Four requesters share one ripple-carry adder feeding a one-entry result  |
// | register. Define ADDER_SCHED_RR_EN for round-robin arbitration,          |
// | otherwise fixed priority with requester 0 highest.                       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module adder_scheduler32 #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    adder_scheduler32_if.slave bus
);
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    logic [WIDTH:0] r_result;
    logic [1:0]     r_id;
    logic [15:0]    r_ops_cnt;
`ifdef ADDER_SCHED_RR_EN
    logic [1:0]     r_ptr;
`endif

    logic             w_can_accept;
    logic             w_xfer;
    logic             w_grant;
    logic [1:0]       w_grant_idx;
    logic [NREQ-1:0]  w_ready;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH:0]   w_sum;

    assign w_can_accept = (r_state == ST_EMPTY) | bus.res_ready_i;
    assign w_xfer       = (r_state == ST_FULL) & bus.res_ready_i;

    // Grants are masked during reset so nothing is accepted that reset would discard.
    always_comb begin : arbiter
        logic [1:0] idx;
        idx         = '0;
        w_ready     = '0;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef ADDER_SCHED_RR_EN
            idx = r_ptr + 2'(i);
`else
            idx = 2'(i);
`endif
            if (!w_grant && bus.req_valid_i[idx]) begin
                w_grant     = 1'b1;
                w_grant_idx = idx;
            end
        end
        if (!(rst_ni && w_can_accept)) begin
            w_grant = 1'b0;
        end
        if (w_grant) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_op_a = bus.add1_i[w_grant_idx*WIDTH +: WIDTH];
    assign w_op_b = bus.add2_i[w_grant_idx*WIDTH +: WIDTH];

    always_comb begin : ripple_adder
        logic carry;
        carry = 1'b0;
        w_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i] = w_op_a[i] ^ w_op_b[i] ^ carry;
            carry    = (w_op_a[i] & w_op_b[i]) | (carry & (w_op_a[i] ^ w_op_b[i]));
        end
        w_sum[WIDTH] = carry;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= ST_EMPTY;
            r_result  <= '0;
            r_id      <= '0;
            r_ops_cnt <= '0;
`ifdef ADDER_SCHED_RR_EN
            r_ptr     <= '0;
`endif
        end else begin
            if (w_xfer) begin
                r_ops_cnt <= r_ops_cnt + 16'd1;
            end
            if (w_grant) begin
                r_state  <= ST_FULL;
                r_result <= w_sum;
                r_id     <= w_grant_idx;
`ifdef ADDER_SCHED_RR_EN
                r_ptr    <= w_grant_idx + 2'd1;
`endif
            end else if (w_xfer) begin
                r_state <= ST_EMPTY;
            end
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.res_valid_o = (r_state == ST_FULL);
    assign bus.result_o    = r_result;
    assign bus.res_id_o    = r_id;
    assign bus.ops_cnt_o   = r_ops_cnt;
endmodule
`default_nettype wire

// File: doc/adder_scheduler32.md
ADDER_SCHEDULER32 -- requirements
Module: adder_scheduler32

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width; results are WIDTH+1 bits.
REQ-002 Parameter NREQ, fixed at 4, SHALL set the number of requesters; the index is 2 bits.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_valid_i  input  NREQ  SHALL carry per-requester operation valid.
REQ-006 req_ready_o  output  NREQ  SHALL carry the per-requester accept strobe: one-hot or zero.
REQ-007 add1_i  input  NREQ*WIDTH  SHALL carry packed first operands; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-008 add2_i  input  NREQ*WIDTH  SHALL carry packed second operands, packed as add1_i.
REQ-009 res_valid_o  output  1  SHALL flag that the result register holds a valid result.
REQ-010 res_ready_i  input  1  SHALL indicate that the consumer accepts the result this cycle.
REQ-011 result_o  output  WIDTH+1  SHALL carry the sum, with carry-out as its MSB.
REQ-012 res_id_o  output  2  SHALL carry the index of the requester that owns result_o.
REQ-013 ops_cnt_o  output  16  SHALL count completed result transfers, wrapping.

Function
REQ-014 The block SHALL contain one shared WIDTH-bit ripple-carry adder with carry-in 0; it is the only adder in the block.
REQ-015 Transfers SHALL occur as follows:
- Request transfer: req_valid_i[k] & req_ready_o[k] in the same cycle.
- Result transfer: res_valid_o & res_ready_i in the same cycle.
REQ-016 Output state machine: two states.
- EMPTY (res_valid_o=0) -> FULL on a grant.
- FULL -> EMPTY on a result transfer with no new grant.
- FULL -> FULL on a result transfer with a simultaneous grant.
- FULL -> FULL, holding, when res_ready_i=0.
REQ-017 can_accept = (state==EMPTY) | res_ready_i; req_ready_o SHALL be zero whenever can_accept=0.
REQ-018 When can_accept=1 and any req_valid_i is set, exactly one bit of req_ready_o SHALL be set, chosen by the arbitration rule (REQ-026/027).
- req_ready_o SHALL depend combinationally on req_valid_i, state, res_ready_i and the pointer only.
REQ-019 On a grant to requester k in cycle N, the block SHALL load the following, and assert res_valid_o in cycle N+1 (latency one cycle):
- result_o = add1_k + add2_k (WIDTH+1 bits, no saturation);
- res_id_o = k.
REQ-020 While FULL and res_ready_i=0, result_o, res_id_o and res_valid_o SHALL hold stable.
REQ-021 With res_ready_i held at 1 and continuous requests, throughput SHALL be one operation per cycle.
REQ-022 ops_cnt_o SHALL increment by 1 per result transfer, wrapping from 0xFFFF to 0x0000.
REQ-023 A requester that deasserts req_valid_i before being granted SHALL lose nothing; no state is held for ungranted requests.

Reset
REQ-024 While rst_ni=0 at a clock edge, the block SHALL set:
- state=EMPTY, res_valid_o=0;
- result_o=0, res_id_o=0;
- ops_cnt_o=0, round-robin pointer=0.
REQ-025 A reset asserted while FULL SHALL discard the held result; no transfer is counted, and req_ready_o SHALL be 0 during reset cycles.

Configuration
REQ-026 With macro ADDER_SCHED_RR_EN defined, arbitration SHALL be round-robin.
- Search starts at pointer p and proceeds p, p+1, ... modulo 4.
- After a grant to k, p becomes (k+1) mod 4; with no grant, p is unchanged.
REQ-027 Without ADDER_SCHED_RR_EN, arbitration SHALL be fixed priority, requester 0 highest; the pointer is absent and all other behaviour is identical.

Verification
REQ-028 Single request: req_valid_i=0001, add1=0xFFFFFFFF, add2=0x00000001, res_ready_i=1 -> req_ready_o=0001; next cycle res_valid_o=1, result_o=0x1_00000000, res_id_o=0, ops_cnt_o=1 after the transfer.
REQ-029 RR_EN, all four valid for 8 cycles, res_ready_i=1 -> grant order 0,1,2,3,0,1,2,3; one result per cycle; ops_cnt_o=8.
REQ-030 No RR_EN, req_valid_i=1010 held -> requester 1 is granted every cycle and requester 3 is never granted.
REQ-031 Backpressure: FULL with result 0x0_00000005, res_ready_i=0 for 3 cycles while req_valid_i=0100 -> req_ready_o=0000, result_o stable; on res_ready_i=1, transfer and grant to requester 2 occur in the same cycle.
REQ-032 Reset mid-operation: FULL, rst_ni=0 for one cycle -> res_valid_o=0, ops_cnt_o=0, pointer=0; the first grant after reset goes to the lowest valid index.
REQ-033 Counter wrap: preload 0xFFFF transfers, then one more -> ops_cnt_o=0x0000.
